rs_multi_issue: RTL and testbench

- Parametrised reservation station for the R10K core, successor to the single-issue RS.
- Accepts up to N renamed instructions per cycle from dispatch and tracks operand readiness via CDB wakeup.
- Squashes or clears entries on branch-stack resolve and mispredict.
- Issues up to ISSUE_W ready entries per cycle, oldest first, under per-port valid/ready handshakes.

---
 rtl/rs_multi_issue_pkg.sv | 33 +++
 rtl/rs_multi_issue_age_select.sv | 15 +
 rtl/rs_multi_issue.sv | 152 +++++++++++++++
 tb/tb_rs_multi_issue.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_multi_issue_pkg.sv
// Shared sizing, entry layout and CDB tag-match helper for the multi-issue reservation station.
package rs_multi_issue_pkg;
  localparam int N            = 3;
  localparam int RS_SZ        = 16;
  localparam int ISSUE_W      = 2;
  localparam int B_MASK_WIDTH = 4;
  localparam int PREG_BITS    = 6;
  localparam int PAYLOAD_W    = 64;
  localparam int SPOT_W       = $clog2(N + 1);
  localparam int OCC_W        = $clog2(RS_SZ + 1);
  localparam int LANE_W       = (N > 1) ? $clog2(N) : 1;

  typedef logic [PREG_BITS-1:0]    phys_reg_idx_t;
  typedef logic [B_MASK_WIDTH-1:0] b_mask_t;

  typedef struct packed {
    logic                 valid;
    phys_reg_idx_t        src1;
    logic                 src1_rdy;
    phys_reg_idx_t        src2;
    logic                 src2_rdy;
    b_mask_t              b_mask;
    logic [PAYLOAD_W-1:0] payload;
  } rs_entry_t;

  // The zero register is ready at rename and must never be woken by a broadcast.
  function automatic logic cdb_hit(phys_reg_idx_t tag, logic [N-1:0] vld,
                                   logic [N*PREG_BITS-1:0] tags);
    cdb_hit = 1'b0;
    for (int j = 0; j < N; j++)
      if (vld[j] && tags[j*PREG_BITS +: PREG_BITS] == tag && tag != '0) cdb_hit = 1'b1;
  endfunction
endpackage

// File: rtl/rs_multi_issue_age_select.sv
// Age-ordered select: an entry goes to port p when exactly p older entries are also requesting.
module rs_multi_issue_age_select
  import rs_multi_issue_pkg::*;
(
  input  logic [RS_SZ-1:0][RS_SZ-1:0]   i_age,   // [r][c] set: entry c is older than entry r
  input  logic [RS_SZ-1:0]              i_req,
  output logic [ISSUE_W-1:0][RS_SZ-1:0] o_gnt
);
  always_comb begin
    o_gnt = '0;
    for (int r = 0; r < RS_SZ; r++)
      for (int p = 0; p < ISSUE_W; p++)
        if (i_req[r] && $countones(i_age[r] & i_req) == p) o_gnt[p][r] = 1'b1;
  end
endmodule

// File: rtl/rs_multi_issue.sv
// Multi-issue reservation station: N-wide dispatch, CDB wakeup, branch squash, oldest-first ISSUE_W select.
// RS_WAKEUP_BYPASS_EN: when defined, this cycle's CDB broadcast also qualifies entries for select.
module rs_multi_issue
  import rs_multi_issue_pkg::*;
(
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [N-1:0]                i_disp_valid,
  input  logic [N*PREG_BITS-1:0]      i_disp_src1,
  input  logic [N*PREG_BITS-1:0]      i_disp_src2,
  input  logic [N-1:0]                i_disp_src1_rdy,
  input  logic [N-1:0]                i_disp_src2_rdy,
  input  logic [N*B_MASK_WIDTH-1:0]   i_disp_b_mask,
  input  logic [N*PAYLOAD_W-1:0]      i_disp_payload,
  output logic [SPOT_W-1:0]           o_rs_spots,
  input  logic [N-1:0]                i_cdb_valid,
  input  logic [N*PREG_BITS-1:0]      i_cdb_tags,
  input  logic [B_MASK_WIDTH-1:0]     i_br_resolve,
  input  logic                        i_br_mispred,
  input  logic [ISSUE_W-1:0]          i_issue_ready,
  output logic [ISSUE_W-1:0]          o_issue_valid,
  output logic [ISSUE_W*PREG_BITS-1:0]    o_issue_src1,
  output logic [ISSUE_W*PREG_BITS-1:0]    o_issue_src2,
  output logic [ISSUE_W*B_MASK_WIDTH-1:0] o_issue_b_mask,
  output logic [ISSUE_W*PAYLOAD_W-1:0]    o_issue_payload,
  output logic [OCC_W-1:0]            o_occupancy
);
  rs_entry_t                    r_ent [RS_SZ];
  logic [RS_SZ-1:0][RS_SZ-1:0]  r_age;
  logic [SPOT_W-1:0]            r_spots;
  logic [OCC_W-1:0]             r_occ;

  rs_entry_t                    w_ent_nxt [RS_SZ];
  logic [RS_SZ-1:0][RS_SZ-1:0]  w_age_nxt;
  logic [RS_SZ-1:0]             w_req, w_kill, w_free, w_keep, w_alloc, w_valid_nxt;
  logic [RS_SZ-1:0][LANE_W-1:0] w_lane;
  logic [ISSUE_W-1:0][RS_SZ-1:0] w_gnt;
  logic [OCC_W-1:0]             w_occ_nxt;
  logic [SPOT_W-1:0]            w_spots_nxt;

  always_comb begin
    for (int e = 0; e < RS_SZ; e++) begin
`ifdef RS_WAKEUP_BYPASS_EN
      w_req[e] = r_ent[e].valid
        && (r_ent[e].src1_rdy || cdb_hit(r_ent[e].src1, i_cdb_valid, i_cdb_tags))
        && (r_ent[e].src2_rdy || cdb_hit(r_ent[e].src2, i_cdb_valid, i_cdb_tags));
`else
      w_req[e] = r_ent[e].valid && r_ent[e].src1_rdy && r_ent[e].src2_rdy;
`endif
      w_kill[e] = r_ent[e].valid && i_br_mispred && |(r_ent[e].b_mask & i_br_resolve);
    end
  end

  rs_multi_issue_age_select u_sel (
    .i_age (r_age),
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  // Squashed picks keep their port but go invalid, so younger entries never backfill.
  always_comb begin
    o_issue_valid   = '0;
    o_issue_src1    = '0;
    o_issue_src2    = '0;
    o_issue_b_mask  = '0;
    o_issue_payload = '0;
    w_free          = '0;
    for (int p = 0; p < ISSUE_W; p++)
      for (int e = 0; e < RS_SZ; e++)
        if (w_gnt[p][e]) begin
          o_issue_valid[p] = !w_kill[e];
          o_issue_src1[p*PREG_BITS +: PREG_BITS]       = r_ent[e].src1;
          o_issue_src2[p*PREG_BITS +: PREG_BITS]       = r_ent[e].src2;
          o_issue_b_mask[p*B_MASK_WIDTH +: B_MASK_WIDTH] = r_ent[e].b_mask & ~i_br_resolve;
          o_issue_payload[p*PAYLOAD_W +: PAYLOAD_W]    = r_ent[e].payload;
          w_free[e] = !w_kill[e] && i_issue_ready[p];
        end
  end

  // Lane k targets the k-th lowest free slot; slots freed this edge are not counted as free.
  always_comb begin : p_disp
    logic [OCC_W-1:0] v_rank;
    v_rank  = '0;
    w_alloc = '0;
    w_lane  = '0;
    for (int e = 0; e < RS_SZ; e++)
      if (!r_ent[e].valid) begin
        if (v_rank < OCC_W'(N)) begin
          w_lane[e]  = LANE_W'(v_rank);
          w_alloc[e] = i_disp_valid[w_lane[e]] && (SPOT_W'(w_lane[e]) < r_spots)
            && !(i_br_mispred
                 && |(i_disp_b_mask[w_lane[e]*B_MASK_WIDTH +: B_MASK_WIDTH] & i_br_resolve));
        end
        v_rank = v_rank + OCC_W'(1);
      end
  end

  always_comb begin : p_next
    logic [LANE_W-1:0] v_l;
    v_l = '0;
    for (int e = 0; e < RS_SZ; e++) begin
      w_keep[e]              = r_ent[e].valid && !w_free[e] && !w_kill[e];
      w_ent_nxt[e]           = r_ent[e];
      w_ent_nxt[e].valid     = w_keep[e];
      w_ent_nxt[e].src1_rdy  = r_ent[e].src1_rdy || cdb_hit(r_ent[e].src1, i_cdb_valid, i_cdb_tags);
      w_ent_nxt[e].src2_rdy  = r_ent[e].src2_rdy || cdb_hit(r_ent[e].src2, i_cdb_valid, i_cdb_tags);
      w_ent_nxt[e].b_mask    = r_ent[e].b_mask & ~i_br_resolve;
      if (w_alloc[e]) begin
        v_l = w_lane[e];
        w_ent_nxt[e].valid    = 1'b1;
        w_ent_nxt[e].src1     = i_disp_src1[v_l*PREG_BITS +: PREG_BITS];
        w_ent_nxt[e].src2     = i_disp_src2[v_l*PREG_BITS +: PREG_BITS];
        w_ent_nxt[e].src1_rdy = i_disp_src1_rdy[v_l]
          || cdb_hit(i_disp_src1[v_l*PREG_BITS +: PREG_BITS], i_cdb_valid, i_cdb_tags);
        w_ent_nxt[e].src2_rdy = i_disp_src2_rdy[v_l]
          || cdb_hit(i_disp_src2[v_l*PREG_BITS +: PREG_BITS], i_cdb_valid, i_cdb_tags);
        w_ent_nxt[e].b_mask   = i_disp_b_mask[v_l*B_MASK_WIDTH +: B_MASK_WIDTH] & ~i_br_resolve;
        w_ent_nxt[e].payload  = i_disp_payload[v_l*PAYLOAD_W +: PAYLOAD_W];
      end
      w_valid_nxt[e] = w_ent_nxt[e].valid;
    end
    // A new row sees every survivor plus lower lanes of the same cycle as older.
    for (int r = 0; r < RS_SZ; r++)
      for (int c = 0; c < RS_SZ; c++)
        w_age_nxt[r][c] = w_alloc[r]
          ? (w_keep[c] || (w_alloc[c] && w_lane[c] < w_lane[r]))
          : (r_age[r][c] && w_keep[c]);
    w_occ_nxt   = OCC_W'($countones(w_valid_nxt));
    w_spots_nxt = (RS_SZ - int'(w_occ_nxt) > N) ? SPOT_W'(N) : SPOT_W'(RS_SZ - int'(w_occ_nxt));
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int e = 0; e < RS_SZ; e++) r_ent[e] <= '0;
      r_age   <= '0;
      r_occ   <= '0;
      r_spots <= SPOT_W'((N < RS_SZ) ? N : RS_SZ);
    end else begin
      for (int e = 0; e < RS_SZ; e++) r_ent[e] <= w_ent_nxt[e];
      r_age   <= w_age_nxt;
      r_occ   <= w_occ_nxt;
      r_spots <= w_spots_nxt;
    end
  end

  assign o_rs_spots  = r_spots;
  assign o_occupancy = r_occ;

  a_disp_overflow: assert property (@(posedge i_clock) disable iff (!i_reset)
    $countones(i_disp_valid) <= int'(r_spots))
    else $error("rs_multi_issue: dispatch count exceeds rs_spots");
endmodule

// File: tb/tb_rs_multi_issue.sv
// Bench for rs_multi_issue: directed scenarios then random traffic, checked against an age-ordered queue model.
module tb_rs_multi_issue;
  import rs_multi_issue_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  logic [N-1:0]                disp_valid, disp_s1_rdy, disp_s2_rdy, cdb_valid;
  logic [N*PREG_BITS-1:0]      disp_s1, disp_s2, cdb_tags;
  logic [N*B_MASK_WIDTH-1:0]   disp_bm;
  logic [N*PAYLOAD_W-1:0]      disp_pl;
  logic [B_MASK_WIDTH-1:0]     br_resolve;
  logic                        br_mispred;
  logic [ISSUE_W-1:0]          issue_ready, issue_valid;
  logic [ISSUE_W*PREG_BITS-1:0]    issue_s1, issue_s2;
  logic [ISSUE_W*B_MASK_WIDTH-1:0] issue_bm;
  logic [ISSUE_W*PAYLOAD_W-1:0]    issue_pl;
  logic [SPOT_W-1:0]           rs_spots;
  logic [OCC_W-1:0]            occupancy;

  rs_multi_issue dut (
    .i_clock(clock), .i_reset(reset_n),
    .i_disp_valid(disp_valid), .i_disp_src1(disp_s1), .i_disp_src2(disp_s2),
    .i_disp_src1_rdy(disp_s1_rdy), .i_disp_src2_rdy(disp_s2_rdy),
    .i_disp_b_mask(disp_bm), .i_disp_payload(disp_pl), .o_rs_spots(rs_spots),
    .i_cdb_valid(cdb_valid), .i_cdb_tags(cdb_tags),
    .i_br_resolve(br_resolve), .i_br_mispred(br_mispred),
    .i_issue_ready(issue_ready), .o_issue_valid(issue_valid),
    .o_issue_src1(issue_s1), .o_issue_src2(issue_s2),
    .o_issue_b_mask(issue_bm), .o_issue_payload(issue_pl), .o_occupancy(occupancy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [PREG_BITS-1:0]    s1, s2;
    bit                      r1, r2;
    logic [B_MASK_WIDTH-1:0] bm;
    logic [PAYLOAD_W-1:0]    pl;
  } ment_t;

  ment_t q[$];            // live entries, oldest first
  int    m_pick [ISSUE_W];
  logic [ISSUE_W-1:0] m_ev;
  int    n_vec = 0, n_err = 0, serial = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int spots_m();
    int f;
    f = RS_SZ - q.size();
    return (f > N) ? N : f;
  endfunction

  function automatic bit m_hit(logic [PREG_BITS-1:0] t);
    m_hit = 1'b0;
    if (t != 0)
      for (int j = 0; j < N; j++)
        if (cdb_valid[j] && cdb_tags[j*PREG_BITS +: PREG_BITS] == t) m_hit = 1'b1;
  endfunction

  function automatic bit m_ready(ment_t e);
`ifdef RS_WAKEUP_BYPASS_EN
    return (e.r1 || m_hit(e.s1)) && (e.r2 || m_hit(e.s2));
`else
    return e.r1 && e.r2;
`endif
  endfunction

  task automatic m_update();
    ment_t nq[$];
    ment_t e;
    bit    gone;
    int    nacc;
    nacc = spots_m();
    for (int i = 0; i < q.size(); i++) begin
      e = q[i];
      gone = br_mispred && ((e.bm & br_resolve) != 0);
      for (int p = 0; p < ISSUE_W; p++)
        if (m_pick[p] == i && m_ev[p] && issue_ready[p]) gone = 1'b1;
      if (!gone) begin
        e.r1 = e.r1 || m_hit(e.s1);
        e.r2 = e.r2 || m_hit(e.s2);
        e.bm = e.bm & ~br_resolve;
        nq.push_back(e);
      end
    end
    for (int k = 0; k < N; k++)
      if (disp_valid[k] && k < nacc) begin
        e.s1 = disp_s1[k*PREG_BITS +: PREG_BITS];
        e.s2 = disp_s2[k*PREG_BITS +: PREG_BITS];
        e.r1 = disp_s1_rdy[k] || m_hit(e.s1);
        e.r2 = disp_s2_rdy[k] || m_hit(e.s2);
        e.bm = disp_bm[k*B_MASK_WIDTH +: B_MASK_WIDTH];
        e.pl = disp_pl[k*PAYLOAD_W +: PAYLOAD_W];
        if (!(br_mispred && ((e.bm & br_resolve) != 0))) begin
          e.bm = e.bm & ~br_resolve;
          nq.push_back(e);
        end
      end
    q = nq;
  endtask

  // One clock: compare outputs at the falling edge, advance the model on the rising edge.
  task automatic cyc();
    int np;
    @(negedge clock);
    np = 0;
    for (int p = 0; p < ISSUE_W; p++) m_pick[p] = -1;
    for (int i = 0; i < q.size(); i++)
      if (np < ISSUE_W && m_ready(q[i])) begin
        m_pick[np] = i;
        np++;
      end
    m_ev = '0;
    for (int p = 0; p < ISSUE_W; p++)
      if (m_pick[p] >= 0) m_ev[p] = !(br_mispred && ((q[m_pick[p]].bm & br_resolve) != 0));
    check("issue_valid", 128'(issue_valid), 128'(m_ev));
    check("occupancy", 128'(occupancy), 128'(q.size()));
    check("rs_spots", 128'(rs_spots), 128'(spots_m()));
    for (int p = 0; p < ISSUE_W; p++)
      if (m_ev[p])
        check($sformatf("issue_port%0d", p),
              {issue_s1[p*PREG_BITS +: PREG_BITS], issue_s2[p*PREG_BITS +: PREG_BITS],
               issue_bm[p*B_MASK_WIDTH +: B_MASK_WIDTH], issue_pl[p*PAYLOAD_W +: PAYLOAD_W]},
              {q[m_pick[p]].s1, q[m_pick[p]].s2, q[m_pick[p]].bm & ~br_resolve, q[m_pick[p]].pl});
    @(posedge clock);
    m_update();
    #1;
  endtask

  task automatic clear_in();
    disp_valid = '0; disp_s1 = '0; disp_s2 = '0; disp_s1_rdy = '0; disp_s2_rdy = '0;
    disp_bm = '0; disp_pl = '0; cdb_valid = '0; cdb_tags = '0;
    br_resolve = '0; br_mispred = 1'b0;
  endtask

  task automatic set_lane(input int k, input logic [PREG_BITS-1:0] s1, input bit r1,
                          input logic [PREG_BITS-1:0] s2, input bit r2,
                          input logic [B_MASK_WIDTH-1:0] bm);
    serial++;
    disp_valid[k] = 1'b1;
    disp_s1[k*PREG_BITS +: PREG_BITS] = s1;
    disp_s2[k*PREG_BITS +: PREG_BITS] = s2;
    disp_s1_rdy[k] = r1;
    disp_s2_rdy[k] = r2;
    disp_bm[k*B_MASK_WIDTH +: B_MASK_WIDTH] = bm;
    disp_pl[k*PAYLOAD_W +: PAYLOAD_W] = {32'(serial), $urandom};
  endtask

  initial begin
    int nd;
    logic [PREG_BITS-1:0] t1, t2;
    reset_n = 1'b0;
    clear_in();
    issue_ready = '0;
    #12;
    check("reset_spots", 128'(rs_spots), 128'(3));
    check("reset_occ", 128'(occupancy), 128'(0));
    check("reset_issue_valid", 128'(issue_valid), 128'(0));
    reset_n = 1'b1;
    repeat (2) cyc();

    // three ready entries, then two ports drain them oldest first
    for (int k = 0; k < N; k++) set_lane(k, 6'd0, 1'b1, 6'd0, 1'b1, 4'd0);
    cyc();
    clear_in();
    check("occ_after_disp", 128'(occupancy), 128'(3));
    issue_ready = 2'b11;
    cyc();
    check("occ_after_issue1", 128'(occupancy), 128'(1));
    cyc();
    check("occ_after_issue2", 128'(occupancy), 128'(0));

    // wakeup on a later cycle, then wakeup in the dispatch cycle
    set_lane(0, 6'd12, 1'b0, 6'd0, 1'b1, 4'd0);
    cyc();
    clear_in();
    cdb_valid[0] = 1'b1; cdb_tags[0 +: PREG_BITS] = 6'd12;
    cyc();
    clear_in();
    cyc();
    set_lane(0, 6'd12, 1'b0, 6'd0, 1'b1, 4'd0);
    cdb_valid[1] = 1'b1; cdb_tags[PREG_BITS +: PREG_BITS] = 6'd12;
    cyc();
    clear_in();
    repeat (2) cyc();

    // fill, release one slot, refill, then stall with ready picks held
    issue_ready = 2'b00;
    for (int it = 0; it < 10 && spots_m() > 0; it++) begin
      nd = spots_m();
      for (int k = 0; k < nd; k++) set_lane(k, 6'd0, 1'b1, 6'd0, 1'b1, 4'd0);
      cyc();
      clear_in();
    end
    check("full_spots", 128'(rs_spots), 128'(0));
    check("full_occ", 128'(occupancy), 128'(16));
    issue_ready = 2'b01;
    cyc();
    check("spots_after_free", 128'(rs_spots), 128'(1));
    issue_ready = 2'b00;
    set_lane(0, 6'd0, 1'b1, 6'd0, 1'b1, 4'd0);
    cyc();
    clear_in();
    repeat (5) cyc();
    issue_ready = 2'b11;
    repeat (10) cyc();

    // mispredict squashes the 0001 entry only; a plain resolve clears the bit on the issue port
    issue_ready = 2'b00;
    set_lane(0, 6'd0, 1'b1, 6'd0, 1'b1, 4'b0001);
    set_lane(1, 6'd0, 1'b1, 6'd0, 1'b1, 4'b0010);
    cyc();
    clear_in();
    br_resolve = 4'b0001; br_mispred = 1'b1;
    cyc();
    clear_in();
    check("occ_after_squash", 128'(occupancy), 128'(1));
    issue_ready = 2'b11;
    repeat (2) cyc();
    issue_ready = 2'b00;
    set_lane(0, 6'd0, 1'b1, 6'd0, 1'b1, 4'b0001);
    set_lane(1, 6'd0, 1'b1, 6'd0, 1'b1, 4'b0010);
    cyc();
    clear_in();
    br_resolve = 4'b0001; issue_ready = 2'b11;
    cyc();
    clear_in();
    repeat (2) cyc();

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      clear_in();
      nd = $urandom_range(spots_m(), 0);
      for (int k = 0; k < nd; k++) begin
        t1 = 6'($urandom_range(15, 0));
        t2 = 6'($urandom_range(15, 0));
        set_lane(k, t1, (t1 == 0) || ($urandom_range(1, 0) == 1),
                 t2, (t2 == 0) || ($urandom_range(1, 0) == 1),
                 ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'd0);
      end
      for (int j = 0; j < N; j++) begin
        cdb_valid[j] = ($urandom_range(1, 0) == 1);
        cdb_tags[j*PREG_BITS +: PREG_BITS] = 6'($urandom_range(15, 0));
      end
      if ($urandom_range(7, 0) == 0) begin
        br_resolve = 4'(1 << $urandom_range(3, 0));
        br_mispred = ($urandom_range(1, 0) == 1);
      end else begin
        br_mispred = ($urandom_range(7, 0) == 0);
      end
      issue_ready = 2'($urandom);
      cyc();
    end

    // drain: broadcast every nonzero tag, then empty the station
    clear_in();
    issue_ready = 2'b11;
    for (int c = 0; c < 20; c++) begin
      for (int j = 0; j < N; j++) begin
        cdb_valid[j] = (c < 5);
        cdb_tags[j*PREG_BITS +: PREG_BITS] = 6'((c * N + j) % 15 + 1);
      end
      cyc();
    end
    check("drain_occ", 128'(occupancy), 128'(0));
    check("drain_spots", 128'(rs_spots), 128'(3));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
